// File: rtl/sad_trigger_ctrl.sv
// sad_trigger_ctrl
// Sequencing controller for the SAD trigger datapath. It runs in the ADC clock
// domain. It primes the SAD window after arming and masks matches until the
// window holds valid samples. It converts the datapath match flag into
// fixed-width trigger pulses and spaces repeated triggers with a hold-off. It
// also keeps sticky triggered/count status for the register block.
//
// Ports:
//   clk_adc          ADC sample clock (the only clock)
//   reset_n          asynchronous active-low reset
//   armed_and_ready  capture armed (level)
//   cfg_short        1 = half-length window; sampled only when arming
//   cfg_multiple     1 = re-arm after each trigger, 0 = one trigger per arm
//   cfg_clear_status one-cycle pulse clearing status_triggered/status_count
//   sad_match        datapath flag: window SAD below threshold
//   sad_clear        one-cycle clear of the datapath window/accumulator
//   sad_enable       datapath accumulate enable
//   trigger          registered trigger pulse
//   status_triggered sticky "triggered since last clear"
//   status_count     saturating trigger count since last clear
//   state_dbg        current FSM state encoding
//
// Handshake: there is no valid/ready pairing here. armed_and_ready is a plain
// level. Dropping it aborts any run in progress on the next clk_adc edge.
module sad_trigger_ctrl #(
    parameter int pREF_SAMPLES   = 32,
    parameter int pMATCH_LATENCY = 2,
    parameter int pTRIG_PULSE    = 2,
    parameter int pCNT_WIDTH     = 8
) (
    input  logic                  clk_adc,
    input  logic                  reset_n,
    input  logic                  armed_and_ready,
    input  logic                  cfg_short,
    input  logic                  cfg_multiple,
    input  logic                  cfg_clear_status,
    input  logic                  sad_match,
    output logic                  sad_clear,
    output logic                  sad_enable,
    output logic                  trigger,
    output logic                  status_triggered,
    output logic [pCNT_WIDTH-1:0] status_count,
    output logic [2:0]            state_dbg
);

    localparam int CW = $clog2(pREF_SAMPLES + pMATCH_LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRIME   = 3'd1,
        S_ACTIVE  = 3'd2,
        S_TRIG    = 3'd3,
        S_HOLDOFF = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [CW-1:0]   win, win_nx;
    logic [CW-1:0]   win_sel;
    logic            trig_entry;

    assign win_sel = cfg_short ? CW'(pREF_SAMPLES / 2) : CW'(pREF_SAMPLES);

    // Next-state logic. sad_match is only looked at inside ACTIVE, so an
    // undriven match flag in any other state cannot reach the outputs.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        win_nx     = win;
        trig_entry = 1'b0;
        case (state)
            S_IDLE: begin
                if (armed_and_ready) begin
                    state_nx = S_PRIME;
                    win_nx   = win_sel;
                    // Fill the window plus the datapath pipeline before a
                    // match can be trusted.
                    cnt_nx   = win_sel + CW'(pMATCH_LATENCY - 1);
                end
            end
            S_PRIME: begin
                if (!armed_and_ready)  state_nx = S_IDLE;
                else if (cnt == '0)    state_nx = S_ACTIVE;
                else                   cnt_nx   = cnt - CW'(1);
            end
            S_ACTIVE: begin
                if (sad_match) begin
                    // Status counts the match even if a disarm on the same
                    // edge prevents the pulse.
                    trig_entry = 1'b1;
                end
                if (!armed_and_ready) begin
                    state_nx = S_IDLE;
                end else if (sad_match) begin
                    state_nx = S_TRIG;
                    cnt_nx   = CW'(pTRIG_PULSE - 1);
                end
            end
            S_TRIG: begin
                if (!armed_and_ready) begin
                    state_nx = S_IDLE;
                end else if (cnt == '0) begin
                    if (cfg_multiple) begin
                        state_nx = S_HOLDOFF;
                        // The hold-off covers the rest of a window length,
                        // measured from the rising edge of the trigger.
                        cnt_nx   = win - CW'(pTRIG_PULSE + 1);
                    end else begin
                        state_nx = S_DONE;
                    end
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            S_HOLDOFF: begin
                if (!armed_and_ready)  state_nx = S_IDLE;
                else if (cnt == '0)    state_nx = S_ACTIVE;
                else                   cnt_nx   = cnt - CW'(1);
            end
            S_DONE: begin
                if (!armed_and_ready)  state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_adc or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            win   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            win   <= win_nx;
        end
    end

    // Outputs are registered from the next state. Each one therefore lines up
    // with the state it belongs to.
    always_ff @(posedge clk_adc or negedge reset_n) begin
        if (!reset_n) begin
            sad_clear  <= 1'b0;
            sad_enable <= 1'b0;
            trigger    <= 1'b0;
        end else begin
            sad_clear  <= (state == S_IDLE) && armed_and_ready;
            sad_enable <= (state_nx == S_PRIME) || (state_nx == S_ACTIVE) ||
                          (state_nx == S_TRIG)  || (state_nx == S_HOLDOFF);
            trigger    <= (state_nx == S_TRIG);
        end
    end

    // A trigger entry wins over a coincident clear. The count then restarts
    // at one.
    always_ff @(posedge clk_adc or negedge reset_n) begin
        if (!reset_n) begin
            status_triggered <= 1'b0;
            status_count     <= '0;
        end else if (trig_entry) begin
            status_triggered <= 1'b1;
            if (cfg_clear_status)
                status_count <= pCNT_WIDTH'(1);
            else if (status_count != {pCNT_WIDTH{1'b1}})
                status_count <= status_count + pCNT_WIDTH'(1);
        end else if (cfg_clear_status) begin
            status_triggered <= 1'b0;
            status_count     <= '0;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_sad_trigger_ctrl.sv
// Testbench for sad_trigger_ctrl. It uses table-driven arm scenarios plus
// hand-written sequences for hold-off spacing, disarm corners, saturation and
// the clear/trigger collision.
module tb_sad_trigger_ctrl;

  localparam int REF   = 32;
  localparam int LAT   = 2;
  localparam int PULSE = 2;
  localparam int CNTW  = 8;

  localparam int S_IDLE    = 0;
  localparam int S_PRIME   = 1;
  localparam int S_ACTIVE  = 2;
  localparam int S_TRIG    = 3;
  localparam int S_HOLDOFF = 4;
  localparam int S_DONE    = 5;

  // PRIME lasts W+LAT cycles (counter W+LAT-1 down to 0). One ACTIVE cycle
  // then samples the match, so the trigger rises W+LAT+1 edges after the arm
  // edge. In multiple mode the period is the pulse plus the hold-off
  // (W-PULSE-1 down to 0) plus one ACTIVE cycle, which is W+1.
  localparam int RISE_FULL  = REF + LAT + 1;
  localparam int RISE_SHORT = REF / 2 + LAT + 1;
  localparam int PERIOD     = REF + 1;

  logic            clk_adc = 1'b0;
  logic            reset_n = 1'b0;
  logic            armed_and_ready = 1'b0;
  logic            cfg_short = 1'b0;
  logic            cfg_multiple = 1'b0;
  logic            cfg_clear_status = 1'b0;
  logic            sad_match = 1'b0;
  logic            sad_clear;
  logic            sad_enable;
  logic            trigger;
  logic            status_triggered;
  logic [CNTW-1:0] status_count;
  logic [2:0]      state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_count = 0;
  logic [31:0] exp_q[$];

  sad_trigger_ctrl #(
    .pREF_SAMPLES(REF), .pMATCH_LATENCY(LAT), .pTRIG_PULSE(PULSE), .pCNT_WIDTH(CNTW)
  ) dut (
    .clk_adc(clk_adc), .reset_n(reset_n), .armed_and_ready(armed_and_ready),
    .cfg_short(cfg_short), .cfg_multiple(cfg_multiple),
    .cfg_clear_status(cfg_clear_status), .sad_match(sad_match),
    .sad_clear(sad_clear), .sad_enable(sad_enable), .trigger(trigger),
    .status_triggered(status_triggered), .status_count(status_count),
    .state_dbg(state_dbg)
  );

  // Clock / reset.
  always #5 clk_adc = ~clk_adc;
  always @(posedge clk_adc) cyc <= cyc + 1;

  typedef struct {
    bit short_w;
    bit multi;
    int exp_rise;
    int exp_width;
    int exp_state;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk_adc);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // Arm with random match noise during PRIME. The match is held at 1 from the
  // first ACTIVE sample onward. cfg_short is flipped after the arm edge.
  task automatic arm_measure(input bit s, input bit m, output int rise, output int width);
    int w;
    w = s ? REF / 2 : REF;
    cfg_short = s;
    cfg_multiple = m;
    armed_and_ready = 1'b1;
    sad_match = 1'($urandom_range(0, 1));
    tick();
    check("arm_sad_clear", sad_clear, 1);
    check("arm_state_prime", state_dbg, S_PRIME);
    check("arm_sad_enable", sad_enable, 1);
    cfg_short = !s;
    rise = -1;
    for (int k = 1; k <= 80; k++) begin
      sad_match = (k > w + LAT) ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
      if (k == 1) check("sad_clear_one_cycle", sad_clear, 0);
      if (trigger) begin
        rise = k;
        break;
      end
    end
    width = 0;
    while (trigger && width < 10) begin
      width++;
      tick();
    end
    if (rise > 0) exp_count = sat_inc(exp_count);
  endtask

  task automatic disarm();
    armed_and_ready = 1'b0;
    sad_match = 1'b0;
    tick();
    check("disarm_state_idle", state_dbg, S_IDLE);
    check("disarm_trigger", trigger, 0);
    check("disarm_sad_enable", sad_enable, 0);
  endtask

  task automatic wait_state(input int st, input string name);
    for (int k = 0; k < 100 && int'(state_dbg) != st; k++) tick();
    check(name, state_dbg, st);
  endtask

  // Arm in single mode and let the pulse run for n_hi cycles. Then disarm.
  task automatic truncate_pulse(input int n_hi);
    int got;
    cfg_short = 1'b1;
    cfg_multiple = 1'b0;
    sad_match = 1'b1;
    armed_and_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      tick();
      if (trigger) got = 1;
    end
    check("trunc_rise_seen", got, 1);
    if (got) exp_count = sat_inc(exp_count);
    for (int k = 1; k < n_hi; k++) begin
      tick();
      check("trunc_still_high", trigger, 1);
    end
    armed_and_ready = 1'b0;
    tick();
    check("trunc_trigger_drop", trigger, 0);
    check("trunc_state_idle", state_dbg, S_IDLE);
    check("trunc_count_kept", status_count, exp_count);
    check("trunc_triggered_kept", status_triggered, 1);
    sad_match = 1'b0;
  endtask

  initial begin
    int rise, width, prev, rises, extra, got;

    vecs[0] = '{short_w: 1'b0, multi: 1'b0, exp_rise: RISE_FULL,  exp_width: PULSE, exp_state: S_DONE};
    vecs[1] = '{short_w: 1'b1, multi: 1'b0, exp_rise: RISE_SHORT, exp_width: PULSE, exp_state: S_DONE};
    vecs[2] = '{short_w: 1'b0, multi: 1'b1, exp_rise: RISE_FULL,  exp_width: PULSE, exp_state: S_HOLDOFF};
    vecs[3] = '{short_w: 1'b1, multi: 1'b1, exp_rise: RISE_SHORT, exp_width: PULSE, exp_state: S_HOLDOFF};

    // Reset state.
    repeat (3) tick();
    check("rst_sad_clear", sad_clear, 0);
    check("rst_sad_enable", sad_enable, 0);
    check("rst_trigger", trigger, 0);
    check("rst_triggered", status_triggered, 0);
    check("rst_count", status_count, 0);
    check("rst_state", state_dbg, S_IDLE);
    reset_n = 1'b1;
    tick();
    check("idle_no_arm", state_dbg, S_IDLE);

    // Table-driven arm scenarios.
    foreach (vecs[i]) begin
      arm_measure(vecs[i].short_w, vecs[i].multi, rise, width);
      check("vec_rise_latency", rise, vecs[i].exp_rise);
      check("vec_pulse_width", width, vecs[i].exp_width);
      check("vec_state_after", state_dbg, vecs[i].exp_state);
      check("vec_count", status_count, exp_count);
      check("vec_triggered", status_triggered, 1);
      if (vecs[i].exp_state == S_DONE) begin
        repeat (5) tick();
        check("done_stays", state_dbg, S_DONE);
        check("done_no_trigger", trigger, 0);
        check("done_sad_enable", sad_enable, 0);
      end else begin
        check("holdoff_enable", sad_enable, 1);
      end
      disarm();
    end

    // Multiple mode, full window, match held: the scoreboard holds the
    // expected rise cycles.
    cfg_short = 1'b0;
    cfg_multiple = 1'b1;
    sad_match = 1'b1;
    armed_and_ready = 1'b1;
    tick();
    for (int k = 0; k < 7; k++) exp_q.push_back(32'(cyc + RISE_FULL + PERIOD * k));
    prev = 0;
    for (int k = 0; k < 250; k++) begin
      tick();
      if (trigger && !prev) begin
        if (exp_q.size() == 0) begin
          check("multi_unexpected_rise", cyc, 0);
        end else begin
          check("multi_rise_cycle", cyc, int'(exp_q.pop_front()));
          exp_count = sat_inc(exp_count);
        end
      end
      prev = trigger;
    end
    check("multi_all_rises", exp_q.size(), 0);
    check("multi_count", status_count, exp_count);
    disarm();

    // Disarm on the second and on the first cycle of a pulse.
    truncate_pulse(2);
    truncate_pulse(1);

    // Disarm on the edge that would enter TRIG: no pulse, but status counts.
    cfg_short = 1'b1;
    cfg_multiple = 1'b0;
    sad_match = 1'b0;
    armed_and_ready = 1'b1;
    wait_state(S_ACTIVE, "reach_active");
    repeat (3) tick();
    check("active_waits_no_match", state_dbg, S_ACTIVE);
    sad_match = 1'b1;
    armed_and_ready = 1'b0;
    tick();
    exp_count = sat_inc(exp_count);
    check("entry_disarm_idle", state_dbg, S_IDLE);
    check("entry_disarm_no_trigger", trigger, 0);
    check("entry_disarm_count", status_count, exp_count);
    sad_match = 1'b0;
    tick();

    // Saturation: run short-window repeated triggers past 255.
    cfg_short = 1'b1;
    cfg_multiple = 1'b1;
    sad_match = 1'b1;
    armed_and_ready = 1'b1;
    prev = 0;
    extra = 0;
    rises = 0;
    for (int k = 0; k < 8000 && extra < 2; k++) begin
      tick();
      if (trigger && !prev) begin
        rises++;
        if (exp_count == 255) extra++;
        exp_count = sat_inc(exp_count);
      end
      prev = trigger;
    end
    check("sat_extra_rises", extra, 2);
    check("sat_count", status_count, 255);

    // Clear coinciding with TRIG entry.
    wait_state(S_ACTIVE, "sat_reach_active");
    cfg_clear_status = 1'b1;
    tick();
    cfg_clear_status = 1'b0;
    exp_count = 1;
    check("clr_entry_state", state_dbg, S_TRIG);
    check("clr_entry_count", status_count, exp_count);
    check("clr_entry_triggered", status_triggered, 1);

    // Plain clear in HOLDOFF: status zeroed, FSM untouched.
    wait_state(S_HOLDOFF, "reach_holdoff");
    cfg_clear_status = 1'b1;
    tick();
    cfg_clear_status = 1'b0;
    exp_count = 0;
    check("clr_count", status_count, exp_count);
    check("clr_triggered", status_triggered, 0);
    check("clr_state_kept", state_dbg, S_HOLDOFF);
    disarm();

    // Re-arm after the clear: a fresh PRIME and a count restarting at one.
    arm_measure(1'b0, 1'b0, rise, width);
    check("rearm_rise", rise, RISE_FULL);
    check("rearm_count", status_count, exp_count);
    disarm();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Overall bound so a stuck run still reaches a verdict.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time exceeded");
    $fatal(1, "timeout");
  end

endmodule
